// File: rtl/mul_pkg.sv
// Shared types and elaboration helpers for the sequential shift-add multiplier.
// Holds the controller state encoding, the iteration-counter width and the WIDTH legality check.
package mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic bit width_legal(input int w);
    return (w >= 2);
  endfunction

endpackage

// File: rtl/mul_fsm.sv
// Controller for seq_multiplier: state register, iteration counter and datapath strobes.
// Status from the datapath is the remaining-multiplier zero flag and its LSB.
module mul_fsm
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic b_zero,
  input  logic b_lsb,
  output logic load,
  output logic clr_acc,
  output logic shift,
  output logic add_en,
  output logic write_product,
  output logic done,
  output logic busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    load          = 1'b0;
    clr_acc       = 1'b0;
    shift         = 1'b0;
    add_en        = 1'b0;
    write_product = 1'b0;
    done          = 1'b0;
    busy          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          load        = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        busy        = 1'b1;
        clr_acc     = 1'b1;
        w_count_nxt = CW'(WIDTH);
        w_state_nxt = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        // Early exit as soon as no multiplier bits remain; the exit cycle does no add.
        if (b_zero || (r_count == '0)) begin
          w_state_nxt = ST_FIX;
        end else begin
          shift       = 1'b1;
          add_en      = b_lsb;
          w_count_nxt = r_count - CW'(1);
        end
      end
      ST_FIX: begin
        busy          = 1'b1;
        write_product = 1'b1;
        w_state_nxt   = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load        = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned, with early termination on the multiplier.
// Works on magnitudes and applies the sign once at the end; start/busy/done handshake.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;

  generate
    if (!width_legal(WIDTH)) begin : g_width_check
      $error("seq_multiplier: WIDTH must be at least 2");
    end
  endgenerate

  // Two's-complement magnitude; the most negative value maps onto its unsigned image.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    logic [WIDTH-1:0] neg_v;
    neg_v = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    return (sgn && v[WIDTH-1]) ? neg_v : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
    logic [PW-1:0] neg_v;
    neg_v = ~v + {{(PW-1){1'b0}}, 1'b1};
    return neg ? neg_v : v;
  endfunction

  logic [WIDTH-1:0] r_a_op;
  logic [WIDTH-1:0] r_b_op;
  logic             r_sgn;
  logic             r_neg;
  logic [PW-1:0]    r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_product;

  logic w_load;
  logic w_clr_acc;
  logic w_shift;
  logic w_add_en;
  logic w_write_product;
  logic w_b_zero;
  logic w_b_lsb;
  logic w_done;
  logic w_busy;

  assign w_b_zero = (r_b_sh == '0);
  assign w_b_lsb  = r_b_sh[0];

  mul_fsm #(
    .WIDTH(WIDTH)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .b_zero        (w_b_zero),
    .b_lsb         (w_b_lsb),
    .load          (w_load),
    .clr_acc       (w_clr_acc),
    .shift         (w_shift),
    .add_en        (w_add_en),
    .write_product (w_write_product),
    .done          (w_done),
    .busy          (w_busy)
  );

  // Operands are frozen on the accepting edge; later input changes are invisible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_op <= '0;
      r_b_op <= '0;
      r_sgn  <= 1'b0;
    end else if (w_load) begin
      r_a_op <= a_in;
      r_b_op <= b_in;
      r_sgn  <= signed_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_neg  <= 1'b0;
    end else if (w_clr_acc) begin
      r_a_sh <= {{WIDTH{1'b0}}, magnitude(r_a_op, r_sgn)};
      r_b_sh <= magnitude(r_b_op, r_sgn);
      r_neg  <= r_sgn & (r_a_op[WIDTH-1] ^ r_b_op[WIDTH-1]);
    end else if (w_shift) begin
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
    end
  end

  // Magnitude product is below 2^PW, so the accumulator never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_clr_acc) begin
      r_acc <= '0;
    end else if (w_shift && w_add_en) begin
      r_acc <= r_acc + r_a_sh;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_product <= '0;
    end else if (w_write_product) begin
      r_product <= apply_sign(r_acc, r_neg);
    end
  end

  assign product = r_product;
  assign done    = w_done;
  assign busy    = w_busy;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier (WIDTH=8) against an arithmetic timing model.
module tb_seq_multiplier;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic int bitlen(input int v);
    int k = 0;
    while ((v >> k) != 0) k++;
    return k;
  endfunction

  function automatic int mag_of(input logic [W-1:0] v, input bit sm);
    return (sm && v[W-1]) ? (256 - int'(v)) : int'(v);
  endfunction

  function automatic logic [15:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    int p;
    if (sm) p = int'($signed(a)) * int'($signed(b));
    else    p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  // Timing model: edge index t0 accepts; busy after edges t0..D-1; done and new product after edge D.
  int          cyc = 0;
  bit          m_act = 1'b0;
  int          m_t0 = 0;
  int          m_D = 0;
  logic [15:0] m_prod = '0;
  logic [15:0] m_val = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  = 1'b0;
      m_prod = '0;
    end else begin
      cyc++;
      if (m_act && cyc == m_D) m_prod = m_val;
      if (start && (!m_act || cyc > m_D)) begin
        m_act = 1'b1;
        m_t0  = cyc;
        m_D   = cyc + 3 + bitlen(mag_of(b_in, signed_mode));
        m_val = ref_prod(a_in, b_in, signed_mode);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_act && cyc >= m_t0 && cyc < m_D)});
      chk("done", {31'd0, done}, {31'd0, (m_act && cyc == m_D)});
      chk("product", {16'd0, product}, {16'd0, m_prod});
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); signed_mode = 1'($urandom);
  endtask

  task automatic wait_done(input string nm, input logic [15:0] ep, input int lat, input int poke);
    int n = 0;
    bit seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else if (lat > 0) chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
      if (!seen && poke > 0 && n == poke) begin
        #1; start = 1'b1; a_in = W'($urandom); b_in = W'($urandom);
      end else if (!seen && poke > 0 && n == poke + 1) begin
        #1; start = 1'b0;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=no_done want=done", nm);
    end else if (lat > 0) begin
      chk({nm, "_latency"}, n, lat);
      chk({nm, "_product"}, {16'd0, product}, {16'd0, ep});
    end
  endtask

  task automatic go(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                    input logic [15:0] ep, input int lat);
    @(negedge clk);
    #1;
    issue(a, b, sm);
    wait_done(nm, ep, lat, 0);
  endtask

  initial begin
    int dcnt;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    go("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, 8);
    go("zero_b", 8'd200, 8'd0, 1'b0, 16'h0000, 4);
    go("s_m7x6", 8'hF9, 8'd6, 1'b1, 16'hFFD6, 7);
    go("s_80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 12);
    go("u_80x80", 8'h80, 8'h80, 1'b0, 16'h4000, 12);
    go("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, 12);
    // Back-to-back from the done cycle, with an ignored start pulse during CALC.
    #1;
    issue(8'd3, 8'd5, 1'b0);
    chk("b2b_load_busy", {31'd0, busy}, 32'd1);
    wait_done("b2b_3x5", 16'h000F, 7, 3);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    #1;
    issue(8'd100, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    go("u2x3", 8'd2, 8'd3, 1'b0, 16'h0006, 6);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap == 0) #1;
      else begin
        repeat (gap) @(negedge clk);
        #1;
      end
      issue(W'($urandom), (i % 5 == 0) ? W'($urandom_range(0, 3)) : W'($urandom), 1'($urandom));
      wait_done("rand", 16'h0000, -1, 0);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier with an integrated controller and datapath. It is the next-generation replacement for the fixed-width repeated-addition multiplier. It adds a WIDTH parameter, signed/unsigned mode and early termination on the remaining multiplier bits, and it presents a start/busy/done handshake to the surrounding arithmetic subsystem.

## Interface
- WIDTH, 8, operand width in bits; must be >= 2. The product is 2*WIDTH bits.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on clk, accepted only while busy=0.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- a_in  in  WIDTH  multiplicand; captured on the accepting edge.
- b_in  in  WIDTH  multiplier; captured on the accepting edge.
- busy  out  1  high in LOAD, CALC and FIX.
- done  out  1  one-cycle pulse in DONE; product is valid from this cycle onward.
- product  out  2*WIDTH  registered result; holds the last result until the next FIX.

## Operation
- States: IDLE, LOAD, CALC, FIX, DONE.
- IDLE:
  - start=1 -> capture a_in, b_in and signed_mode into internal registers, then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Form the magnitudes |a| and |b| as WIDTH-bit unsigned values. Negate an operand only when signed_mode=1 and its MSB is 1.
  - -2^(WIDTH-1) maps to 2^(WIDTH-1) and fits.
  - neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear the accumulator. Load the 2*WIDTH shift register A with |a| and the WIDTH register B with |b|.
  - Set the iteration count to WIDTH. Go to CALC.
- CALC, one cycle per iteration:
  - If B==0 or count==0 -> go to FIX. No accumulation happens in that cycle.
  - Otherwise: if B[0]=1, acc += A. Then A <<= 1, B >>= 1, count -= 1.
- FIX:
  - product <= neg ? -acc : acc, truncated to 2*WIDTH bits.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - If start=1 in this cycle, capture the new operands and go to LOAD (back-to-back). Otherwise go to IDLE.
- start while busy=1 is ignored and has no side effects.
- Operands are sampled only on the accepting edge. Later changes to a_in, b_in or signed_mode do not affect the operation in progress.
- The accumulator is 2*WIDTH bits and cannot overflow, because the unsigned magnitude product is < 2^(2*WIDTH).
- Negating a zero result gives 0. There is no negative zero.

## Timing
- Reset values: busy=0, done=0, product=0, state=IDLE. All internal registers are 0.
- Latency: let k be the bit length of |b| (k=0 for b=0; k<=WIDTH). Counting the accepting edge as edge 0:
  - LOAD occupies cycle 1.
  - CALC occupies cycles 2 .. 2+k (k adds plus one exit cycle).
  - FIX occupies cycle 3+k.
  - done is high in cycle 4+k.
- product updates on the edge that ends FIX, so it is stable in the done cycle. It is unchanged at every other time except reset.
- Back-to-back throughput: a start held high through DONE begins the next LOAD in the cycle after done, with no idle gap.
- rst asserted in any state returns all outputs to their reset values immediately, without waiting for clk. A pending result is discarded, and done is not generated for the aborted operation.
- If rst deasserts while start=1, start is accepted on the first rising edge that has rst low.

## Structure
- Shared package mul_pkg holds:
  - the state enum (IDLE, LOAD, CALC, FIX, DONE);
  - the count-width function clog2(WIDTH+1);
  - the WIDTH >= 2 legality check.
- One sub-module, mul_fsm, holds the state register, iteration counter and control outputs:
  - control outputs: load, clr_acc, shift, add_en, write_product, done, busy;
  - status inputs: start, b_zero, b_lsb.
- The datapath (operand registers, magnitude/negate logic, accumulator, product register) lives in seq_multiplier.

## Test plan
All scenarios use WIDTH=8.
- Unsigned 13 x 11: start with a_in=13, b_in=11, signed_mode=0 -> product=16'h008F. done is high exactly 8 cycles after the accepting edge (k=4). busy is high for cycles 1..7.
- Zero multiplier: a_in=200, b_in=0, unsigned -> product=0 and done at cycle 4. No add occurs; the accumulator stays 0.
- Signed mixed sign: a_in=8'hF9 (-7), b_in=6, signed_mode=1 -> product=16'hFFD6 (-42), done at cycle 7.
- Signed extreme: a_in=b_in=8'h80, signed_mode=1 -> product=16'h4000, done at cycle 12. Same operands with signed_mode=0 -> product=16'h4000.
- Unsigned full scale and back-to-back:
  - 255 x 255 -> product=16'hFE01.
  - Hold start high with new operands 3 x 5 through DONE -> LOAD follows immediately, and the second done gives product=16'h000F.
  - A start pulse during CALC is ignored: the result and done timing are unchanged.
- Reset mid-operation: assert rst during CALC of 100 x 100 -> busy, done and product go to 0 at once, with no done pulse afterwards. A new 2 x 3 then completes with product=6.
